proteus_nbout_writeback: RTL



---
 rtl/proteus_nbout_writeback.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/proteus_nbout_writeback.sv
// NBout packed-word writeback: FIFO buffer plus sequential-address memory writer with start/done/overflow status.
// Optional build macro PROTEUS_WB_PARITY_EN adds per-lane parity of the presented write word.
module proteus_nbout_writeback #(
    parameter int N      = 16,
    parameter int Tn     = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_base_addr,
    input  logic [CNT_W-1:0]         i_num_words,
    input  logic                     i_valid,
    input  logic [N*Tn-1:0]          i_data,
    output logic                     o_ready,
    output logic                     o_mem_valid,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [N*Tn-1:0]          o_mem_data,
    input  logic                     i_mem_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef PROTEUS_WB_PARITY_EN
    ,
    output logic [Tn-1:0]            o_mem_parity
`endif
);
    // state | meaning
    // IDLE  | waiting for i_start
    // RUN   | accepting packer words and writing them back
    // DONE  | one-cycle completion pulse, then IDLE
    localparam int DW = N * Tn;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [DW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  accept_left;
    logic [CNT_W-1:0]  write_left;
    logic              overflow;

    logic full, empty, can_take, push, drop, pop, last;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign can_take = (state == S_RUN) && i_valid && (accept_left != '0);
    // A full FIFO never accepts, even when the head is leaving this cycle.
    assign push     = can_take && !full;
    assign drop     = can_take && full;
    assign pop      = !empty && i_mem_ready;
    assign last     = pop && (write_left == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr        <= '0;
            accept_left <= '0;
            write_left  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                accept_left <= accept_left - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr   <= addr + ADDR_W'(1);
                if (write_left != '0) begin
                    write_left <= write_left - CNT_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_num_words != '0) begin
                            state       <= S_RUN;
                            addr        <= i_base_addr;
                            accept_left <= i_num_words;
                            write_left  <= i_num_words;
                            overflow    <= 1'b0;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_ready     = !full;
    assign o_mem_valid = !empty;
    assign o_mem_addr  = addr;
    assign o_mem_data  = empty ? '0 : mem[rd_ptr];
    assign o_busy      = (state == S_RUN);
    assign o_done      = (state == S_DONE);
    assign o_overflow  = overflow;
    assign o_count     = count;

`ifdef PROTEUS_WB_PARITY_EN
    // Data is forced to zero when empty, so parity reads zero then as well.
    always_comb begin
        o_mem_parity = '0;
        for (int i = 0; i < Tn; i++) begin
            o_mem_parity[i] = ^o_mem_data[i*N +: N];
        end
    end
`endif

endmodule
